mac2_accum: RTL

- Sequential multiply-accumulate stage downstream of the team's 2-bit combinational multiplier (mult2Bit).
- Accepts a stream of 2-bit operand pairs over a valid/ready handshake and forms each 4-bit product with one mult2Bit instance.
- Sums the products into a wide accumulator and presents the total, term count and overflow flag over an output valid/ready handshake.

---
 rtl/mac2_accum_pkg.sv | 12 +
 rtl/mult2Bit.sv | 23 ++
 rtl/mac2_accum.sv | 84 ++++++++
 3 files changed

// File: rtl/mac2_accum_pkg.sv
// Shared types and widths for the mac2_accum multiply-accumulate stage.
package mac2_accum_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

    localparam int unsigned PROD_W = 4;
    localparam int unsigned OPND_W = 2;

endpackage

// File: rtl/mult2Bit.sv
// 2-bit x 2-bit unsigned combinational multiplier; bit 0 is the LSB on all ports.
module mult2Bit (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);

    logic w_pp10;
    logic w_pp01;
    logic w_pp11;
    logic w_c1;

    assign w_pp10 = i_a[1] & i_b[0];
    assign w_pp01 = i_a[0] & i_b[1];
    assign w_pp11 = i_a[1] & i_b[1];
    assign w_c1   = w_pp10 & w_pp01;

    assign o_p[0] = i_a[0] & i_b[0];
    assign o_p[1] = w_pp10 ^ w_pp01;
    assign o_p[2] = w_pp11 ^ w_c1;
    assign o_p[3] = w_pp11 & w_c1;

endmodule

// File: rtl/mac2_accum.sv
// Accumulates 2-bit x 2-bit products into a frame total with a sticky carry-out flag;
// a frame closes on in_last or after MAX_TERMS terms and is handed off over valid/ready.
module mac2_accum
    import mac2_accum_pkg::*;
#(
    parameter int unsigned ACC_W     = 8,
    parameter int unsigned MAX_TERMS = 16,
    parameter int unsigned CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    state_e             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;

    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W:0]     w_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_accept;
    logic               w_close;

    mult2Bit u_mult (
        .i_a (a),
        .i_b (b),
        .o_p (w_prod)
    );

    // One extra bit on the adder captures the carry that feeds the sticky flag.
    assign w_nxt     = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, w_prod};
    assign w_cnt_inc = r_count + CNT_W'(1);
    assign w_accept  = in_valid && (r_state == ACC);
    assign w_close   = in_last || (w_cnt_inc == CNT_W'(MAX_TERMS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_nxt[ACC_W-1:0];
                        r_ovf   <= r_ovf | w_nxt[ACC_W];
                        r_count <= w_cnt_inc;
                        if (w_close) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= ACC;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Handshake flags decode the state register only, so no input reaches them combinationally.
    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == DONE);
    assign sum       = r_acc;
    assign count     = r_count;
    assign overflow  = r_ovf;

endmodule
